// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_pkg
// Purpose  : Shared state, size and segment-map constants for dmem_bridge.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_ADDR = 2'd1,
        DMB_DATA = 2'd2,
        DMB_DONE = 2'd3
    } dmb_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // kseg0/kseg1 select pattern on the top two address bits, and how many
    // top bits are cleared to reach the physical address.
    localparam logic [1:0] SEG_KSEG01   = 2'b10;
    localparam int         SEG_CLR_BITS = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_addr_map.sv
`default_nettype none
// ============================================================================
// Module   : dmem_addr_map
// Purpose  : Fixed MIPS segment map; kseg0/kseg1 fold onto physical space.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_addr_map
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_addr
);

    logic w_kseg01;

    assign w_kseg01 = (i_addr[ADDR_W-1 -: 2] == SEG_KSEG01);
    assign o_addr   = w_kseg01 ? {{SEG_CLR_BITS{1'b0}}, i_addr[ADDR_W-SEG_CLR_BITS-1:0]}
                               : i_addr;

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : M-stage bridge from single-cycle SRAM-style access to a
//            req/addr_ok/data_ok memory. Optional macro DMEM_ADDR_MAP_EN
//            enables the kseg0/kseg1 address map on mem_addr.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmb_state_t        r_state;
    logic              r_req;
    logic              r_busy;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] w_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DMB_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= 4'd0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                DMB_IDLE: begin
                    if (cpu_en) begin
                        r_wr    <= |cpu_wen;
                        r_size  <= cpu_size;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wstrb <= cpu_wen;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= DMB_ADDR;
                    end
                end
                DMB_ADDR: begin
                    if (mem_data_ok && !r_wr) begin
                        r_rdata <= mem_rdata;
                    end
                    if (mem_addr_ok) begin
                        r_req <= 1'b0;
                        if (mem_data_ok) begin
                            r_busy  <= 1'b0;
                            r_state <= DMB_DONE;
                        end else begin
                            r_state <= DMB_DATA;
                        end
                    end
                end
                DMB_DATA: begin
                    if (mem_data_ok) begin
                        if (!r_wr) begin
                            r_rdata <= mem_rdata;
                        end
                        r_busy  <= 1'b0;
                        r_state <= DMB_DONE;
                    end
                end
                DMB_DONE: begin
                    r_state <= DMB_IDLE;
                end
                default: begin
                    r_state <= DMB_IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the very cycle the access is presented in IDLE.
    assign stall_mem = r_busy | ((r_state == DMB_IDLE) & cpu_en);

`ifdef DMEM_ADDR_MAP_EN
    dmem_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .i_addr (r_addr),
        .o_addr (w_mem_addr)
    );
`else
    assign w_mem_addr = r_addr;
`endif

    assign mem_req   = r_req;
    assign mem_wr    = r_wr;
    assign mem_size  = r_size;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign cpu_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Purpose  : Self-checking bench for dmem_bridge: directed table, corner
//            sequences and randomized transactions against a schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_rdata  = 32'd0;

    always #5 clk = ~clk;

    dmem_bridge #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_size    (cpu_size),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .stall_mem   (stall_mem),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          a_dly;
        int          d_dly;
        int          exp_stall;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
        if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_cycle(input bit dok);
        cpu_en      = 1'b0;
        cpu_wen     = 4'($urandom);
        cpu_addr    = $urandom;
        mem_addr_ok = 1'b0;
        mem_data_ok = dok;
        mem_rdata   = $urandom;
        @(negedge clk);
        chk("idle_stall", {31'd0, stall_mem}, 32'd0);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        chk("idle_rdata", cpu_rdata, m_rdata);
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
    endtask

    // One access: a = cycles of mem_req before addr_ok, d = cycles from
    // acceptance to data_ok (0 = same cycle). Schedule index k: 0 is the
    // presenting cycle, 1..a+1 request cycles, last = a+d+2 is the release cycle.
    task automatic run_txn(input logic [3:0] wen, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int a, input int d,
                           input bit keep_en, input bit spur,
                           output int stall_cnt, output logic [31:0] maddr_seen,
                           output logic [31:0] rdata_done);
        int          last;
        logic [31:0] exp_rd;
        last       = a + d + 2;
        stall_cnt  = 0;
        maddr_seen = 32'hXXXX_XXXX;
        rdata_done = 32'd0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                cpu_en = 1'b1; cpu_wen = wen; cpu_size = size;
                cpu_addr = addr; cpu_wdata = wdata;
            end else begin
                cpu_en    = (k == last) ? keep_en : 1'($urandom_range(0, 1));
                cpu_wen   = 4'($urandom);
                cpu_size  = 2'($urandom);
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            mem_addr_ok = (k == a + 1);
            mem_data_ok = (k == a + 1 + d) || ((k == last) && spur);
            mem_rdata   = (k == a + 1 + d) ? rdata : $urandom;
            @(negedge clk);
            chk("stall", {31'd0, stall_mem}, {31'd0, (k < last)});
            if (stall_mem) stall_cnt++;
            chk("req", {31'd0, mem_req}, {31'd0, (k >= 1 && k <= a + 1)});
            if (k >= 1 && k <= a + 1) begin
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, (wen != 4'd0)});
                chk("mem_size", {30'd0, mem_size}, {30'd0, size});
                chk("mem_addr", mem_addr, map_addr(addr));
                chk("mem_wdata", mem_wdata, wdata);
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, wen});
                maddr_seen = mem_addr;
            end
            if (k == last) begin
                exp_rd = (wen == 4'd0) ? rdata : m_rdata;
                chk("rdata_done", cpu_rdata, exp_rd);
                m_rdata    = exp_rd;
                rdata_done = cpu_rdata;
            end
            @(posedge clk); #1;
        end
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    vec_t        tbl[6];
    int          sc;
    logic [31:0] ma;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_size = 2'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;

        tbl[0] = '{4'b0000, 2'd2, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 2,
                   32'h0000_0010, 32'hDEAD_BEEF};
        tbl[1] = '{4'b0011, 2'd1, 32'h0000_0202, 32'h0000_1234, 32'hBAD0_BAD0, 2, 2, 6,
                   32'h0000_0202, 32'hDEAD_BEEF};
`ifdef DMEM_ADDR_MAP_EN
        tbl[2] = '{4'b0000, 2'd2, 32'hBFC0_0100, 32'h0, 32'h0123_4567, 1, 1, 4,
                   32'h1FC0_0100, 32'h0123_4567};
        tbl[3] = '{4'b1111, 2'd2, 32'h8000_0040, 32'hA5A5_5A5A, 32'h1111_1111, 0, 3, 5,
                   32'h0000_0040, 32'h0123_4567};
        tbl[4] = '{4'b0000, 2'd0, 32'hA000_0004, 32'h0, 32'hCAFE_F00D, 3, 0, 5,
                   32'h0000_0004, 32'hCAFE_F00D};
`else
        tbl[2] = '{4'b0000, 2'd2, 32'hBFC0_0100, 32'h0, 32'h0123_4567, 1, 1, 4,
                   32'hBFC0_0100, 32'h0123_4567};
        tbl[3] = '{4'b1111, 2'd2, 32'h8000_0040, 32'hA5A5_5A5A, 32'h1111_1111, 0, 3, 5,
                   32'h8000_0040, 32'h0123_4567};
        tbl[4] = '{4'b0000, 2'd0, 32'hA000_0004, 32'h0, 32'hCAFE_F00D, 3, 0, 5,
                   32'hA000_0004, 32'hCAFE_F00D};
`endif
        tbl[5] = '{4'b0000, 2'd2, 32'h4000_0008, 32'h0, 32'h55AA_55AA, 0, 1, 3,
                   32'h4000_0008, 32'h55AA_55AA};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_fields", {mem_wr, mem_size, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle(1'b0);

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].wen, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                    tbl[i].a_dly, tbl[i].d_dly, 1'b0, 1'(i % 2), sc, ma, rd);
            chk("tbl_stall_cycles", sc, tbl[i].exp_stall);
            chk("tbl_mem_addr", ma, tbl[i].exp_maddr);
            chk("tbl_rdata", rd, tbl[i].exp_rdata);
            idle_cycle(1'b0);
        end

        // Back-to-back loads with cpu_en held through the release cycle.
        run_txn(4'd0, 2'd2, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 0, 0, 1'b1, 1'b0, sc, ma, rd);
        run_txn(4'd0, 2'd2, 32'h0000_0104, 32'h0, 32'h2468_ACE0, 1, 2, 1'b0, 1'b0, sc, ma, rd);
        chk("b2b_rdata", rd, 32'h2468_ACE0);

        // Spurious data_ok while idle.
        repeat (3) idle_cycle(1'b1);

        // Reset while waiting in the data phase.
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_size = 2'd2; cpu_addr = 32'h0000_0300;
        @(negedge clk);
        chk("rstseq_stall0", {31'd0, stall_mem}, 32'd1);
        @(posedge clk); #1;
        cpu_en = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("rstseq_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        chk("rstseq_wait_stall", {31'd0, stall_mem}, 32'd1);
        chk("rstseq_wait_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rstseq_stall", {31'd0, stall_mem}, 32'd0);
        chk("rstseq_req0", {31'd0, mem_req}, 32'd0);
        chk("rstseq_rdata", cpu_rdata, 32'd0);
        chk("rstseq_wstrb", {28'd0, mem_wstrb}, 32'd0);
        m_rdata = 32'd0;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        idle_cycle(1'b0);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  w;
            logic [31:0] a;
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            case ($urandom_range(0, 2))
                0:       a = {2'b10, 30'($urandom)};
                1:       a = {2'b00, 30'($urandom)};
                default: a = $urandom;
            endcase
            run_txn(w, 2'($urandom_range(0, 2)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sc, ma, rd);
            if ($urandom_range(0, 1) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
